// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Command sequencer around an external combinational 16-bit
//               ALU. Accepts one command at a time, drives the ALU for the
//               arithmetic opcodes, keeps a 32-bit accumulator and sticky
//               error flags, and returns one response per command.
// Ports       : clk, rst           - clock, async active-high reset
//               CmdValid/CmdReady  - command handshake
//               CmdOpCode/Operand  - command opcode (4b) and operand (16b)
//               AluA/AluB/AluOpCode- ALU operand/opcode drive
//               AluResult/AluError - ALU result (32b), errors (ovf, div0)
//               Acc, ErrorSticky   - accumulator and sticky ALU errors
//               RspValid/RspReady  - response handshake, RspError status
//               Busy               - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [3:0]  CmdOpCode,
    input  logic [15:0] CmdOperand,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [3:0]  AluOpCode,
    input  logic [31:0] AluResult,
    input  logic [1:0]  AluError,
    output logic [31:0] Acc,
    output logic [1:0]  ErrorSticky,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [1:0]  RspError,
    output logic        Busy
);

    localparam logic [3:0] c_OP_NOOP  = 4'b0000;
    localparam logic [3:0] c_OP_CLEAR = 4'b0001;
    localparam logic [3:0] c_OP_LOAD  = 4'b0010;
    localparam logic [3:0] c_OP_ADD   = 4'b0100;
    localparam logic [3:0] c_OP_SUB   = 4'b0101;
    localparam logic [3:0] c_OP_MUL   = 4'b0110;
    localparam logic [3:0] c_OP_DIV   = 4'b0111;
    localparam logic [3:0] c_OP_MOD   = 4'b1000;

    localparam logic [1:0] c_ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t      r_state_q,  w_state_d;
    logic [31:0] r_acc_q,    w_acc_d;
    logic [1:0]  r_sticky_q, w_sticky_d;
    logic [1:0]  r_rsp_err_q, w_rsp_err_d;
    logic [15:0] r_alu_a_q,  w_alu_a_d;
    logic [15:0] r_alu_b_q,  w_alu_b_d;
    logic [3:0]  r_alu_op_q, w_alu_op_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_acc_q     <= 32'd0;
            r_sticky_q  <= 2'b00;
            r_rsp_err_q <= 2'b00;
            r_alu_a_q   <= 16'd0;
            r_alu_b_q   <= 16'd0;
            r_alu_op_q  <= 4'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_acc_q     <= w_acc_d;
            r_sticky_q  <= w_sticky_d;
            r_rsp_err_q <= w_rsp_err_d;
            r_alu_a_q   <= w_alu_a_d;
            r_alu_b_q   <= w_alu_b_d;
            r_alu_op_q  <= w_alu_op_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_acc_d     = r_acc_q;
        w_sticky_d  = r_sticky_q;
        w_rsp_err_d = r_rsp_err_q;
        w_alu_a_d   = r_alu_a_q;
        w_alu_b_d   = r_alu_b_q;
        w_alu_op_d  = r_alu_op_q;

        case (r_state_q)
            S_IDLE: begin
                // CmdReady is high throughout IDLE, so CmdValid alone is the
                // accept condition here.
                if (CmdValid) begin
                    w_rsp_err_d = 2'b00;
                    w_state_d   = S_RESPOND;
                    case (CmdOpCode)
                        c_OP_NOOP: ;
                        c_OP_CLEAR: begin
                            w_acc_d    = 32'd0;
                            w_sticky_d = 2'b00;
                        end
                        c_OP_LOAD: begin
                            w_acc_d = {{16{CmdOperand[15]}}, CmdOperand};
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_MUL, c_OP_DIV, c_OP_MOD: begin
                            // Only the low half of the accumulator is an ALU operand.
                            w_alu_a_d  = r_acc_q[15:0];
                            w_alu_b_d  = CmdOperand;
                            w_alu_op_d = CmdOpCode;
                            w_state_d  = S_ISSUE;
                        end
                        default: begin
                            w_rsp_err_d = c_ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                // One cycle of settling time for the combinational ALU.
                w_state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (AluError == 2'b00) begin
                    w_acc_d     = AluResult;
                    w_rsp_err_d = 2'b00;
                end else begin
                    w_rsp_err_d = AluError;
                    w_sticky_d  = r_sticky_q | AluError;
                end
                w_alu_a_d  = 16'd0;
                w_alu_b_d  = 16'd0;
                w_alu_op_d = 4'd0;
                w_state_d  = S_RESPOND;
            end
            S_RESPOND: begin
                if (RspReady) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign CmdReady    = (r_state_q == S_IDLE);
    assign Busy        = (r_state_q != S_IDLE);
    assign RspValid    = (r_state_q == S_RESPOND);
    assign RspError    = r_rsp_err_q;
    assign Acc         = r_acc_q;
    assign ErrorSticky = r_sticky_q;
    assign AluA        = r_alu_a_q;
    assign AluB        = r_alu_b_q;
    assign AluOpCode   = r_alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a
//               behavioural model of the external 16-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [3:0] c_NOOP  = 4'b0000;
    localparam logic [3:0] c_CLEAR = 4'b0001;
    localparam logic [3:0] c_LOAD  = 4'b0010;
    localparam logic [3:0] c_ADD   = 4'b0100;
    localparam logic [3:0] c_SUB   = 4'b0101;
    localparam logic [3:0] c_MUL   = 4'b0110;
    localparam logic [3:0] c_DIV   = 4'b0111;
    localparam logic [3:0] c_MOD   = 4'b1000;
    localparam logic [3:0] c_ILL   = 4'b1010;

    logic        clk = 1'b0;
    logic        rst;
    logic        CmdValid;
    logic        CmdReady;
    logic [3:0]  CmdOpCode;
    logic [15:0] CmdOperand;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [3:0]  AluOpCode;
    logic [31:0] AluResult;
    logic [1:0]  AluError;
    logic [31:0] Acc;
    logic [1:0]  ErrorSticky;
    logic        RspValid;
    logic        RspReady;
    logic [1:0]  RspError;
    logic        Busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_acc = 32'd0;

    always #5 clk = ~clk;

    alu_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOpCode  (CmdOpCode),
        .CmdOperand (CmdOperand),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluOpCode  (AluOpCode),
        .AluResult  (AluResult),
        .AluError   (AluError),
        .Acc        (Acc),
        .ErrorSticky(ErrorSticky),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspError   (RspError),
        .Busy       (Busy)
    );

    // External ALU: signed 16-bit operands, 32-bit result.
    logic signed [16:0] w_sum;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;

    always_comb begin
        AluResult = 32'd0;
        AluError  = 2'b00;
        w_sum     = 17'sd0;
        w_sa      = {{16{AluA[15]}}, AluA};
        w_sb      = {{16{AluB[15]}}, AluB};
        case (AluOpCode)
            c_ADD: begin
                w_sum       = $signed({AluA[15], AluA}) + $signed({AluB[15], AluB});
                AluResult   = {{15{w_sum[16]}}, w_sum};
                AluError[0] = (w_sum[16] != w_sum[15]);
            end
            c_SUB: begin
                w_sum       = $signed({AluA[15], AluA}) - $signed({AluB[15], AluB});
                AluResult   = {{15{w_sum[16]}}, w_sum};
                AluError[0] = (w_sum[16] != w_sum[15]);
            end
            c_MUL: AluResult = w_sa * w_sb;
            c_DIV: begin
                if (AluB == 16'd0) AluError = 2'b10;
                else               AluResult = w_sa / w_sb;
            end
            c_MOD: begin
                if (AluB == 16'd0) AluError = 2'b10;
                else               AluResult = w_sa % w_sb;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one command, measure edges from accept to RspValid, check the
    // response, optionally stall RspReady while offering another command,
    // then complete the response.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] opd, input int exp_lat,
                          input logic [31:0] exp_acc, input logic [1:0] exp_err,
                          input logic [1:0] exp_sticky, input int hold);
        int lat;
        @(negedge clk);
        check("cmd_ready", 32'(CmdReady), 32'd1);
        CmdValid   = 1'b1;
        CmdOpCode  = op;
        CmdOperand = opd;
        @(posedge clk);
        #1;
        CmdValid   = 1'b0;
        CmdOpCode  = c_CLEAR;
        CmdOperand = 16'hDEAD;
        check("busy", 32'(Busy), 32'd1);
        if (exp_lat == 2) begin
            check("alu_a", 32'(AluA), {16'd0, last_acc[15:0]});
            check("alu_b", 32'(AluB), {16'd0, opd});
            check("alu_op", 32'(AluOpCode), {28'd0, op});
        end
        lat = 0;
        while (!RspValid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("acc", Acc, exp_acc);
        check("rsp_err", 32'(RspError), {30'd0, exp_err});
        check("sticky", 32'(ErrorSticky), {30'd0, exp_sticky});
        check("alu_op_idle", 32'(AluOpCode), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            CmdValid   = 1'b1;
            CmdOpCode  = c_LOAD;
            CmdOperand = 16'h1234;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(RspValid), 32'd1);
            check("hold_ready", 32'(CmdReady), 32'd0);
            check("hold_err", 32'(RspError), {30'd0, exp_err});
        end
        CmdValid = 1'b0;
        @(negedge clk);
        RspReady = 1'b1;
        @(posedge clk);
        #1;
        RspReady = 1'b0;
        check("rsp_done", 32'(RspValid), 32'd0);
        check("idle_ready", 32'(CmdReady), 32'd1);
        check("acc_after", Acc, exp_acc);
        last_acc = exp_acc;
    endtask

    initial begin
        rst        = 1'b1;
        CmdValid   = 1'b0;
        CmdOpCode  = 4'd0;
        CmdOperand = 16'd0;
        RspReady   = 1'b0;
        #1;
        check("rst_acc", Acc, 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(CmdReady), 32'd1);
        check("rel_valid", 32'(RspValid), 32'd0);
        check("rel_sticky", 32'(ErrorSticky), 32'd0);
        check("rel_alu_a", 32'(AluA), 32'd0);

        do_cmd(c_LOAD,  16'd100,  0, 32'd100,      2'b00, 2'b00, 0);
        do_cmd(c_ADD,   16'd150,  2, 32'd250,      2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'h4844, 0, 32'h00004844, 2'b00, 2'b00, 0);
        do_cmd(c_ADD,   16'h52EE, 2, 32'h00004844, 2'b01, 2'b01, 0);
        do_cmd(c_CLEAR, 16'd0,    0, 32'd0,        2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'd21,   0, 32'd21,       2'b00, 2'b00, 0);
        do_cmd(c_DIV,   16'd0,    2, 32'd21,       2'b10, 2'b10, 0);
        do_cmd(c_CLEAR, 16'd0,    0, 32'd0,        2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'd221,  0, 32'd221,      2'b00, 2'b00, 0);
        do_cmd(c_MUL,   16'd116,  2, 32'd25636,    2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'hFFFF, 0, 32'hFFFFFFFF, 2'b00, 2'b00, 0);
        do_cmd(c_NOOP,  16'h5555, 0, 32'hFFFFFFFF, 2'b00, 2'b00, 0);
        do_cmd(c_ADD,   16'd1,    2, 32'd0,        2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'd5,    0, 32'd5,        2'b00, 2'b00, 0);
        do_cmd(c_SUB,   16'd7,    2, 32'hFFFFFFFE, 2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'd23,   0, 32'd23,       2'b00, 2'b00, 0);
        do_cmd(c_MOD,   16'd5,    2, 32'd3,        2'b00, 2'b00, 0);
        do_cmd(c_LOAD,  16'h7FFF, 0, 32'h00007FFF, 2'b00, 2'b00, 0);
        do_cmd(c_ADD,   16'd1,    2, 32'h00007FFF, 2'b01, 2'b01, 0);
        do_cmd(c_ILL,   16'h0042, 0, 32'h00007FFF, 2'b11, 2'b01, 5);
        do_cmd(c_LOAD,  16'd10,   0, 32'd10,       2'b00, 2'b01, 0);

        // Reset in the middle of an ADD aborts it without a response.
        @(negedge clk);
        CmdValid   = 1'b1;
        CmdOpCode  = c_ADD;
        CmdOperand = 16'd5;
        @(posedge clk);
        #1;
        CmdValid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_alu_op", 32'(AluOpCode), {28'd0, c_ADD});
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_acc", Acc, 32'd0);
        check("mid_rst_valid", 32'(RspValid), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_alu_a", 32'(AluA), 32'd0);
        check("mid_rst_sticky", 32'(ErrorSticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", 32'(RspValid), 32'd0);
        end
        check("post_rst_acc", Acc, 32'd0);
        check("post_rst_ready", 32'(CmdReady), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
